clkgate_ctrl: RTL and testbench
===============================

CLKGATE_CTRL -- requirements
Module: clkgate_ctrl

Interface
REQ-001 Parameter N_DOM, default 4: number of gated clock domains, range 1..16.
REQ-002 Parameter IDLE_CYC, default 16: consecutive idle cycles before a domain is gated off, range 2..1024.
REQ-003 Parameter WAKE_LAT, default 2: cycles between re-enable and ready, range 1..15.
REQ-004 CK  input  1  single clock; all state updates on posedge CK.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 force_on  input  1  global override; holds every domain enabled.
REQ-007 busy  input  N_DOM  per-domain activity indication.
REQ-008 wake_req  input  N_DOM  per-domain explicit wake request, level-sensitive.
REQ-009 en  output  N_DOM  registered enable, one bit per clock-gate cell E pin.
REQ-010 ready  output  N_DOM  registered; gated clock stable and usable.
REQ-011 stats_clr  input  1  clears statistics counters; present only with CLKGATE_CTRL_STATS_EN.
REQ-012 gated_cnt  output  16*N_DOM  per-domain gated-cycle counters, domain i in bits [16i+15:16i]; present only with CLKGATE_CTRL_STATS_EN.

Function
REQ-013 Each domain shall run an independent FSM with states ON, OFF and WAKE.
REQ-014 A domain is active in a cycle when busy[i], wake_req[i] or force_on is 1.
REQ-015 ON: en=1, ready=1; idle counter increments on each inactive cycle and clears to 0 on each active cycle.
REQ-016 ON to OFF after IDLE_CYC consecutive inactive cycles: first inactive cycle t0 gives en=0, ready=0 from cycle t0+IDLE_CYC.
REQ-017 An active cycle coinciding with the expiring idle count shall keep the domain in ON and clear the counter; activity wins.
REQ-018 OFF: en=0, ready=0; any active cycle moves to WAKE with en=1 on the next cycle.
REQ-019 WAKE: en=1, ready=0 for exactly WAKE_LAT cycles, then ON with ready=1 and idle counter 0; inputs are ignored during WAKE.
REQ-020 Latency from active cycle t in OFF: en=1 at t+1, ready=1 at t+1+WAKE_LAT.
REQ-021 en shall change only at posedge CK from a flop, never from combinational decode, so the gate cell's latch sees no glitches.
REQ-022 ready shall never be 1 while en is 0.
REQ-023 Counter widths shall be $clog2 of the parameter maximum; counters shall not wrap within the legal parameter range.

Reset
REQ-024 RST=1 at posedge CK shall force every domain to ON, with en=all ones, ready=all ones and idle and wake counters 0, regardless of the current state (including mid-WAKE).
REQ-025 With the macro enabled, RST shall also clear gated_cnt to 0.

Configuration
REQ-026 Macro CLKGATE_CTRL_STATS_EN, when defined, adds stats_clr, gated_cnt and per-domain 16-bit saturating counters.
REQ-027 Each counter increments every cycle en[i]=0 and saturates at 0xFFFF.
REQ-028 stats_clr=1 shall zero all counters at the next edge; it takes priority over increment.
REQ-029 When CLKGATE_CTRL_STATS_EN is undefined, the stats_clr and gated_cnt ports and the counter logic shall be absent; all other behaviour is identical.

Structure
REQ-030 Package clkgate_ctrl_pkg shall hold the FSM state enum (ON, OFF, WAKE), the constant STATS_W=16 and the parameter maximum constants.
REQ-031 Sub-module clkgate_dom_fsm shall implement one domain's FSM, idle counter and wake counter; the top shall instantiate it N_DOM times and hold force_on fan-out and the stats counters.

Verification
REQ-032 Reset then busy=0, wake_req=0, force_on=0, IDLE_CYC=16 -> en[i] falls at cycle 16 after the first idle cycle and ready[i] falls with it.
REQ-033 Domain OFF, wake_req[0] pulsed at cycle t with WAKE_LAT=2 -> en[0]=1 at t+1, ready[0]=1 at t+3, other domains unchanged.
REQ-034 busy[1] asserted on the 16th idle cycle -> domain 1 stays ON, and en[1] falls 16 cycles after busy[1] drops.
REQ-035 force_on=1 with all domains OFF -> all en=1 next cycle and ready=1 after WAKE_LAT; no domain gates while force_on=1.
REQ-036 RST asserted during WAKE -> en=1 and ready=1 on the next cycle.
REQ-037 With CLKGATE_CTRL_STATS_EN, domain gated for 70000 cycles -> gated_cnt=0xFFFF; then stats_clr -> 0x0000, and counting resumes at 1 on the following gated cycle.

Source files
------------

// File: rtl/clkgate_ctrl_pkg.sv
// clkgate_ctrl_pkg: shared types and limits for the clock-gate controller.
// Holds the domain FSM state enum, stats width and parameter maxima.
package clkgate_ctrl_pkg;

    typedef enum logic [1:0] {
        ON   = 2'd0,
        OFF  = 2'd1,
        WAKE = 2'd2
    } dom_state_e;

    localparam int STATS_W      = 16;
    localparam int N_DOM_MAX    = 16;
    localparam int IDLE_CYC_MAX = 1024;
    localparam int WAKE_LAT_MAX = 15;

    // Counters sized from the legal maxima so no legal setting can wrap.
    localparam int IDLE_W = $clog2(IDLE_CYC_MAX);
    localparam int WAKE_W = $clog2(WAKE_LAT_MAX);
    localparam int DOM_W  = $clog2(N_DOM_MAX);

    function automatic logic [STATS_W-1:0] sat_inc(
        input logic [STATS_W-1:0] v
    );
        return (v == '1) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/clkgate_ctrl_if.sv
// clkgate_ctrl_if: activity inputs and enable/ready outputs of the controller.
// Signals: force_on, busy, wake_req (to ctrl); en, ready (from ctrl);
// stats_clr, gated_cnt only with CLKGATE_CTRL_STATS_EN.
interface clkgate_ctrl_if #(
    parameter int N_DOM = 4
);
    logic             force_on;
    logic [N_DOM-1:0] busy;
    logic [N_DOM-1:0] wake_req;
    logic [N_DOM-1:0] en;
    logic [N_DOM-1:0] ready;
`ifdef CLKGATE_CTRL_STATS_EN
    logic                stats_clr;
    logic [16*N_DOM-1:0] gated_cnt;
`endif

    modport master (
        output force_on,
        output busy,
        output wake_req,
`ifdef CLKGATE_CTRL_STATS_EN
        output stats_clr,
        input  gated_cnt,
`endif
        input  en,
        input  ready
    );

    modport slave (
        input  force_on,
        input  busy,
        input  wake_req,
`ifdef CLKGATE_CTRL_STATS_EN
        input  stats_clr,
        output gated_cnt,
`endif
        output en,
        output ready
    );
endinterface

// File: rtl/clkgate_dom_fsm.sv
// clkgate_dom_fsm: one gated domain's ON/OFF/WAKE FSM with idle and wake
// counters. Ports: CK, RST, active_i (in); en_o, ready_o (registered out).
module clkgate_dom_fsm
    import clkgate_ctrl_pkg::*;
#(
    parameter int IDLE_CYC = 16,
    parameter int WAKE_LAT = 2
) (
    input  logic CK,
    input  logic RST,
    input  logic active_i,
    output logic en_o,
    output logic ready_o
);

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_LAT - 1);

    dom_state_e        state_q, state_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [WAKE_W-1:0] wake_q, wake_d;
    logic              en_q, en_d;
    logic              ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        wake_d  = wake_q;
        unique case (state_q)
            ON: begin
                // Activity wins over an expiring idle count.
                if (active_i) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = OFF;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            OFF: begin
                if (active_i) begin
                    state_d = WAKE;
                    wake_d  = '0;
                end
            end
            WAKE: begin
                if (wake_q == WAKE_LAST) begin
                    state_d = ON;
                    wake_d  = '0;
                    idle_d  = '0;
                end else begin
                    wake_d = wake_q + WAKE_W'(1);
                end
            end
            default: begin
                state_d = ON;
                idle_d  = '0;
                wake_d  = '0;
            end
        endcase
        // Outputs come from their own flops so en never glitches.
        en_d    = (state_d != OFF);
        ready_d = (state_d == ON);
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= ON;
            idle_q  <= '0;
            wake_q  <= '0;
            en_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
            en_q    <= en_d;
            ready_q <= ready_d;
        end
    end

    assign en_o    = en_q;
    assign ready_o = ready_q;

endmodule

// File: rtl/clkgate_ctrl.sv
// clkgate_ctrl: idle-driven clock-gate enable controller for N_DOM domains.
// Ports: CK, RST (sync, active-high), bus (clkgate_ctrl_if.slave).
// Optional macro CLKGATE_CTRL_STATS_EN adds saturating gated-cycle counters.
module clkgate_ctrl
    import clkgate_ctrl_pkg::*;
#(
    parameter int N_DOM    = 4,
    parameter int IDLE_CYC = 16,
    parameter int WAKE_LAT = 2
) (
    input  logic          CK,
    input  logic          RST,
    clkgate_ctrl_if.slave bus
);

    logic [N_DOM-1:0] active;
    logic [N_DOM-1:0] en_w;
    logic [N_DOM-1:0] ready_w;

    assign active = bus.busy | bus.wake_req | {N_DOM{bus.force_on}};

    for (genvar g = 0; g < N_DOM; g++) begin : g_dom
        clkgate_dom_fsm #(
            .IDLE_CYC (IDLE_CYC),
            .WAKE_LAT (WAKE_LAT)
        ) u_dom (
            .CK       (CK),
            .RST      (RST),
            .active_i (active[g]),
            .en_o     (en_w[g]),
            .ready_o  (ready_w[g])
        );
    end

    assign bus.en    = en_w;
    assign bus.ready = ready_w;

`ifdef CLKGATE_CTRL_STATS_EN
    logic [STATS_W-1:0] cnt_q [N_DOM];
    logic [STATS_W-1:0] cnt_d [N_DOM];

    // Clear takes priority; a domain counts each cycle its en flop is low.
    always_comb begin
        for (int i = 0; i < N_DOM; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.stats_clr) begin
                cnt_d[i] = '0;
            end else if (!en_w[i]) begin
                cnt_d[i] = sat_inc(cnt_q[i]);
            end
        end
    end

    always_ff @(posedge CK) begin
        for (int i = 0; i < N_DOM; i++) begin
            if (RST) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < N_DOM; g++) begin : g_cnt
        assign bus.gated_cnt[STATS_W*g +: STATS_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_clkgate_ctrl.sv
// tb_clkgate_ctrl: directed, table-driven bench for clkgate_ctrl
// (N_DOM=4, IDLE_CYC=16, WAKE_LAT=2); stats checks with CLKGATE_CTRL_STATS_EN.
module tb_clkgate_ctrl;

    logic CK  = 1'b0;
    logic RST = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   mon_on = 1'b0;

    always #5 CK = ~CK;

    clkgate_ctrl_if #(.N_DOM(4)) bus ();

    clkgate_ctrl #(
        .N_DOM    (4),
        .IDLE_CYC (16),
        .WAKE_LAT (2)
    ) dut (
        .CK  (CK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic       force_on;
        logic [3:0] busy;
        logic [3:0] wake;
        int         reps;
        logic [3:0] en;
        logic [3:0] rdy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm, input logic f, input logic [3:0] b,
                       input logic [3:0] w, input int r,
                       input logic [3:0] e, input logic [3:0] rd);
        vec_t v;
        v.name = nm; v.force_on = f; v.busy = b; v.wake = w;
        v.reps = r; v.en = e; v.rdy = rd;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic drive(input logic f, input logic [3:0] b,
                         input logic [3:0] w);
        bus.force_on = f;
        bus.busy     = b;
        bus.wake_req = w;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    // ready must never be high while en is low.
    always @(negedge CK) begin
        if (mon_on) begin
            checks++;
            if ((bus.ready & ~bus.en) !== 4'h0) begin
                errors++;
                $display("FAIL ready_without_en: en=%b ready=%b",
                         bus.en, bus.ready);
            end
        end
    end

    initial begin
        drive(1'b0, 4'h0, 4'h0);
`ifdef CLKGATE_CTRL_STATS_EN
        bus.stats_clr = 1'b0;
`endif
        tick();
        tick();
        chk("reset_en", 32'(bus.en), 32'hF);
        chk("reset_ready", 32'(bus.ready), 32'hF);
`ifdef CLKGATE_CTRL_STATS_EN
        chk("reset_cnt", bus.gated_cnt[31:0], 32'h0);
        chk("reset_cnt_hi", bus.gated_cnt[63:32], 32'h0);
`endif
        RST = 1'b0;
        mon_on = 1'b1;

        add("idle15",     1'b0, 4'h0, 4'h0, 15, 4'hF, 4'hF);
        add("idle16_off", 1'b0, 4'h0, 4'h0,  1, 4'h0, 4'h0);
        add("wake0_t1",   1'b0, 4'h0, 4'h1,  1, 4'h1, 4'h0);
        add("wake0_t2",   1'b0, 4'h0, 4'h0,  1, 4'h1, 4'h0);
        add("wake0_t3",   1'b0, 4'h0, 4'h0,  1, 4'h1, 4'h1);
        add("force_t1",   1'b1, 4'h0, 4'h0,  1, 4'hF, 4'h1);
        add("force_t2",   1'b1, 4'h0, 4'h0,  1, 4'hF, 4'h1);
        add("force_t3",   1'b1, 4'h0, 4'h0,  1, 4'hF, 4'hF);
        add("force_hold", 1'b1, 4'h0, 4'h0, 40, 4'hF, 4'hF);
        add("rel_idle15", 1'b0, 4'h0, 4'h0, 15, 4'hF, 4'hF);
        add("rel_off",    1'b0, 4'h0, 4'h0,  1, 4'h0, 4'h0);
        add("busy2_t1",   1'b0, 4'h4, 4'h0,  1, 4'h4, 4'h0);
        add("busy2_t2",   1'b0, 4'h4, 4'h0,  1, 4'h4, 4'h0);
        add("busy2_t3",   1'b0, 4'h4, 4'h0,  1, 4'h4, 4'h4);
        add("dom2_idle",  1'b0, 4'h0, 4'h0, 15, 4'h4, 4'h4);
        add("dom2_off",   1'b0, 4'h0, 4'h0,  1, 4'h0, 4'h0);
        add("mix_t1",     1'b0, 4'h8, 4'h2,  1, 4'hA, 4'h0);

        foreach (vq[k]) begin
            drive(vq[k].force_on, vq[k].busy, vq[k].wake);
            for (int r = 0; r < vq[k].reps; r++) tick();
            chk({vq[k].name, "_en"}, 32'(bus.en), 32'(vq[k].en));
            chk({vq[k].name, "_rdy"}, 32'(bus.ready), 32'(vq[k].rdy));
        end

        // Activity on the expiring idle cycle keeps domain 1 on.
        drive(1'b0, 4'h0, 4'h0);
        do_reset();
        for (int i = 0; i < 15; i++) tick();
        drive(1'b0, 4'h2, 4'h0);
        tick();
        chk("race_en", 32'(bus.en), 32'h2);
        chk("race_rdy", 32'(bus.ready), 32'h2);
        drive(1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 15; i++) tick();
        chk("race_hold_en", 32'(bus.en), 32'h2);
        tick();
        chk("race_off_en", 32'(bus.en), 32'h0);
        chk("race_off_rdy", 32'(bus.ready), 32'h0);

        // Reset in the middle of a wake-up.
        drive(1'b0, 4'h0, 4'hF);
        tick();
        chk("midwake_en", 32'(bus.en), 32'hF);
        chk("midwake_rdy", 32'(bus.ready), 32'h0);
        drive(1'b0, 4'h0, 4'h0);
        do_reset();
        chk("rst_wake_en", 32'(bus.en), 32'hF);
        chk("rst_wake_rdy", 32'(bus.ready), 32'hF);

`ifdef CLKGATE_CTRL_STATS_EN
        for (int i = 0; i < 16; i++) tick();
        chk("st_off_en", 32'(bus.en), 32'h0);
        chk("st_zero", bus.gated_cnt[15:0], 32'h0);
        for (int i = 0; i < 10; i++) tick();
        chk("st_ten", bus.gated_cnt[15:0], 32'd10);
        for (int i = 0; i < 70000; i++) tick();
        chk("st_sat0", bus.gated_cnt[15:0], 32'hFFFF);
        chk("st_sat3", bus.gated_cnt[63:48], 32'hFFFF);
        bus.stats_clr = 1'b1;
        tick();
        chk("st_clr", bus.gated_cnt[15:0], 32'h0);
        bus.stats_clr = 1'b0;
        tick();
        chk("st_resume", bus.gated_cnt[15:0], 32'h1);
`endif

        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
